// File: rtl/ucode_pkg.sv
// Shared types and helpers for the microcode sequencer: FSM states, the bundle
// record stored in the queue, and the END-flag scan.
package ucode_pkg;
  localparam int DEF_INSTR_W     = 32;
  localparam int UOP_END_BIT     = DEF_INSTR_W - 1;
  localparam int DEF_FETCH_WIDTH = 2;
  localparam int MAX_FETCH_WIDTH = 4;
  localparam int IDX_W           = $clog2(MAX_FETCH_WIDTH + 1);

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_FETCH, SEQ_DRAIN} seq_state_t;

  typedef struct packed {
    logic [DEF_FETCH_WIDTH*DEF_INSTR_W-1:0] slots;
    logic [$clog2(DEF_FETCH_WIDTH+1)-1:0]   count;
  } uop_bundle_t;

  // Index of the lowest set END flag; MAX_FETCH_WIDTH when none is set.
  function automatic logic [IDX_W-1:0] first_end_idx(input logic [MAX_FETCH_WIDTH-1:0] end_flags);
    first_end_idx = IDX_W'(MAX_FETCH_WIDTH);
    for (int i = MAX_FETCH_WIDTH - 1; i >= 0; i--)
      if (end_flags[i]) first_end_idx = IDX_W'(i);
  endfunction
endpackage

// File: rtl/ucode_sequencer_fifo.sv
// Bundle queue between the uop buffer read port and decode. Clear has priority
// over push/pop; free_entries feeds the fetch credit check.
module uop_bundle_fifo
  import ucode_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = uop_bundle_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CNT_W   = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  entry_t           wr_data,
  output entry_t           rd_data,
  output logic             empty,
  output logic [CNT_W-1:0] free_entries
);
  entry_t           mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNT_W-1:0] occupancy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage carries no reset; the top gates the head with out_valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wr_data;
  end

  assign rd_data      = mem[rd_ptr];
  assign empty        = (occupancy == '0);
  assign free_entries = CNT_W'(DEPTH) - occupancy;
endmodule

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: walks the uop buffer from a start address and feeds bundles
// to decode through a small queue. Define UCODE_BYPASS_EN to let a return skip an empty queue.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int  UOP_BUF_SIZE = 64,
  parameter int  FETCH_WIDTH  = DEF_FETCH_WIDTH,
  parameter int  QUEUE_DEPTH  = 4,
  parameter int  INSTR_W      = UOP_END_BIT + 1,
  localparam int AW           = $clog2(UOP_BUF_SIZE),
  localparam int BW           = FETCH_WIDTH * INSTR_W,
  localparam int CW           = $clog2(FETCH_WIDTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
  output logic          fetch_req,
  output logic [AW-1:0] uop_addr,
  input  logic [BW-1:0] uop_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out_bundle,
  output logic [CW-1:0] out_count,
  output logic          busy,
  output logic          done
);
  localparam int QW = $clog2(QUEUE_DEPTH) + 1;

  typedef struct packed {
    logic [BW-1:0] slots;
    logic [CW-1:0] count;
  } bundle_t;

  seq_state_t                 state, state_next;
  logic [AW-1:0]              pc, pc_next;
  logic                       rd_pending;
  logic [MAX_FETCH_WIDTH-1:0] end_flags;
  logic [IDX_W-1:0]           end_idx;
  logic                       has_end;
  logic                       ret_end;
  bundle_t                    ret_bundle;
  bundle_t                    head_bundle;
  bundle_t                    out_sel;
  logic                       fifo_push;
  logic                       fifo_pop;
  logic                       fifo_empty;
  logic [QW-1:0]              free_entries;

  // Shape the returning bundle: trim at the first END slot and zero what follows.
  always_comb begin
    end_flags = '0;
    for (int i = 0; i < FETCH_WIDTH; i++)
      end_flags[i] = uop_data[i*INSTR_W + INSTR_W - 1];
    end_idx    = first_end_idx(end_flags);
    has_end    = (end_idx < IDX_W'(FETCH_WIDTH));
    ret_end    = rd_pending && has_end;
    ret_bundle = '0;
    for (int i = 0; i < FETCH_WIDTH; i++)
      if (IDX_W'(i) <= end_idx)
        ret_bundle.slots[i*INSTR_W +: INSTR_W] = uop_data[i*INSTR_W +: INSTR_W];
    ret_bundle.count = has_end ? CW'(end_idx + IDX_W'(1)) : CW'(FETCH_WIDTH);
  end

  // A read is issued only when the queue can absorb it plus the one still in flight.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    done       = 1'b0;
    fetch_req  = (state == SEQ_FETCH) && !redirect && !ret_end &&
                 (free_entries > QW'(rd_pending));
    if (fetch_req) pc_next = pc + AW'(FETCH_WIDTH);
    unique case (state)
      SEQ_IDLE: begin
        if (start) begin
          state_next = SEQ_FETCH;
          pc_next    = start_addr;
        end
      end
      SEQ_FETCH: begin
        if (ret_end) state_next = SEQ_DRAIN;
      end
      SEQ_DRAIN: begin
        if (fifo_empty && !rd_pending) begin
          state_next = SEQ_IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = SEQ_IDLE;
    endcase
    if (redirect) begin
      state_next = SEQ_FETCH;
      pc_next    = redirect_addr;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SEQ_IDLE;
      pc         <= '0;
      rd_pending <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      rd_pending <= fetch_req;
    end
  end

`ifdef UCODE_BYPASS_EN
  logic bypass_hit;

  always_comb begin
    bypass_hit = rd_pending && fifo_empty && !redirect;
    out_valid  = !fifo_empty || bypass_hit;
    out_sel    = fifo_empty ? ret_bundle : head_bundle;
    fifo_push  = rd_pending && !redirect && !(bypass_hit && out_ready);
  end
`else
  always_comb begin
    out_valid = !fifo_empty;
    out_sel   = head_bundle;
    fifo_push = rd_pending && !redirect;
  end
`endif

  assign fifo_pop   = !fifo_empty && out_ready && !redirect;
  assign out_bundle = out_valid ? out_sel.slots : '0;
  assign out_count  = out_valid ? out_sel.count : '0;
  assign uop_addr   = pc;
  assign busy       = (state != SEQ_IDLE);

  uop_bundle_fifo #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (bundle_t)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (fifo_push),
    .pop          (fifo_pop),
    .clear        (redirect),
    .wr_data      (ret_bundle),
    .rd_data      (head_bundle),
    .empty        (fifo_empty),
    .free_entries (free_entries)
  );
endmodule
